buffer_parallel_serial: RTL and testbench

Parallel-in, serial-out unloader for the SAD datapath. It is the reader-side counterpart of the serial-in byte buffer. It captures a full flat block of `BUF_SIZE` bytes in one cycle. It then streams the bytes out one per accepted beat over a valid/ready handshake. Byte ordering matches the serial-in buffer's flat layout, so a serial→parallel→serial round trip preserves the byte stream.

---
 rtl/buffer_parallel_serial_pkg.sv | 13 +
 rtl/buffer_parallel_serial.sv | 97 +++++++++
 tb/tb_buffer_parallel_serial.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/buffer_parallel_serial_pkg.sv
// Shared constants and state encoding for the SAD byte buffers.
package buffer_parallel_serial_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BUF_SIZE  = 80;
  localparam int unsigned PTR_WIDTH = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/buffer_parallel_serial.sv
// Parallel-in, serial-out unloader: captures a flat block of BUF_SIZE
// elements in one cycle, then streams them out over valid/ready.
module buffer_parallel_serial #(
  parameter int unsigned WIDTH     = buffer_parallel_serial_pkg::WIDTH,
  parameter int unsigned BUF_SIZE  = buffer_parallel_serial_pkg::BUF_SIZE,
  parameter int unsigned PTR_WIDTH = buffer_parallel_serial_pkg::PTR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [BUF_SIZE*WIDTH-1:0] buf_in,
  output logic                      ld_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          buf_out,
  output logic                      out_last,
  output logic                      buf_empty
);

  import buffer_parallel_serial_pkg::*;

  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(BUF_SIZE - 1);

  state_t               state;
  state_t               next_state;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] next_ptr;
  logic                 capture;
  logic                 at_last;
  logic [WIDTH-1:0]     storage [BUF_SIZE];

  assign at_last = (rd_ptr == LAST_IDX);

  // Next-state and read-pointer logic; load is only honoured in IDLE
  always_comb begin
    next_state = state;
    next_ptr   = rd_ptr;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          next_state = STREAM;
          next_ptr   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (at_last) begin
            next_state = IDLE;
            next_ptr   = '0;
          end else begin
            next_ptr = rd_ptr + PTR_WIDTH'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_ptr   = '0;
      end
    endcase
  end

  // State and read-pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
    end else begin
      state  <= next_state;
      rd_ptr <= next_ptr;
    end
  end

  // Parallel capture of the whole block; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned k = 0; k < BUF_SIZE; k++) begin
        storage[k] <= buf_in[WIDTH*k +: WIDTH];
      end
    end
  end

  // Outputs depend only on registered state and the selected storage entry
  always_comb begin
    ld_ready  = (state == IDLE);
    buf_empty = (state == IDLE);
    out_valid = (state == STREAM);
    out_last  = 1'b0;
    buf_out   = '0;
    if (state == STREAM) begin
      buf_out  = storage[rd_ptr];
      out_last = at_last;
    end
  end

endmodule

// File: tb/tb_buffer_parallel_serial.sv
// Directed self-checking bench for buffer_parallel_serial.
module tb_buffer_parallel_serial;

  localparam int W = 8;
  localparam int N = 80;

  logic           clk;
  logic           rst;
  logic           load;
  logic [N*W-1:0] buf_in;
  logic           ld_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   buf_out;
  logic           out_last;
  logic           buf_empty;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  buffer_parallel_serial #(
    .WIDTH(W),
    .BUF_SIZE(N),
    .PTR_WIDTH(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .buf_in(buf_in),
    .ld_ready(ld_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .buf_out(buf_out),
    .out_last(out_last),
    .buf_empty(buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: k+1, mode 1: 0xA0^k, mode 2: all 0xFF
  function automatic logic [W-1:0] elem(input int mode, input int k);
    logic [W-1:0] v;
    case (mode)
      0:       v = W'(k + 1);
      1:       v = 8'hA0 ^ W'(k);
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  task automatic set_block(input int mode);
    for (int k = 0; k < N; k++) buf_in[k*W +: W] = elem(mode, k);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_empty"}, buf_empty, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_out"}, buf_out, 0);
  endtask

  task automatic check_beat(input string tag, input int mode, input int k);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_data"}, buf_out, elem(mode, k));
    check({tag, "_last"}, out_last, (k == N - 1) ? 1 : 0);
  endtask

  task automatic stream_full(input string tag, input int mode);
    for (int k = 0; k < N; k++) begin
      check_beat(tag, mode, k);
      step();
    end
  endtask

  initial begin
    int expv;
    int c;

    rst       = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    buf_in    = '0;

    // Reset asserted mid-cycle takes effect immediately
    #3 rst = 1'b1;
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ld_ready", ld_ready, 1);
      check("idle_valid", out_valid, 0);
    end

    // Full stream at one element per cycle
    set_block(0);
    load      = 1'b1;
    out_ready = 1'b1;
    step();
    load = 1'b0;
    stream_full("full", 0);
    check_idle("full_end");

    // Backpressure with out_ready pattern 1,0,0,1,0,0,...
    set_block(0);
    load = 1'b1;
    step();
    load = 1'b0;
    expv = 1;
    c    = 0;
    while (expv <= N && c < 400) begin
      out_ready = (c % 3 == 0);
      check("bp_valid", out_valid, 1);
      check("bp_data", buf_out, expv);
      check("bp_last", out_last, (expv == N) ? 1 : 0);
      step();
      if (out_ready) expv++;
      c++;
    end
    check("bp_transfers", expv - 1, N);
    check("bp_cycles", c, 3 * N - 2);
    out_ready = 1'b1;
    check_idle("bp_end");

    // Load during element 40 is ignored
    set_block(0);
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 39) begin
        load = 1'b1;
        set_block(2);
      end else if (k == 40) begin
        load = 1'b0;
      end
      check_beat("ign", 0, k);
      step();
    end
    check_idle("ign_end");

    // Back-to-back blocks with load held high
    set_block(0);
    load = 1'b1;
    step();
    set_block(1);
    stream_full("b2b_first", 0);
    check("b2b_bubble_ld_ready", ld_ready, 1);
    check("b2b_bubble_valid", out_valid, 0);
    step();
    load = 1'b0;
    stream_full("b2b_second", 1);
    check_idle("b2b_end");

    // Reset in the middle of a stream
    set_block(0);
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check_beat("mid", 0, k);
      step();
    end
    check("mid_elem20", buf_out, 21);
    #1 rst = 1'b1;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle("mid_after");
    set_block(1);
    load = 1'b1;
    step();
    load = 1'b0;
    stream_full("mid_reload", 1);
    check_idle("mid_reload_end");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
